// File: rtl/qs_bank_arb.sv
// Bank manager for the queue-sort datapath: per-bank lifecycle FSM, exclusive
// client ownership, access routing into single-port SRAM banks, registered read return.
module qs_bank_arb #(
   parameter int BANKS_N = 4,
   parameter int W       = 32,
   parameter int N       = 256,
   localparam int ADDR_W = $clog2(N),
   localparam int BID_W  = $clog2(BANKS_N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           enq_cmd,
   input  logic [BID_W-1:0]     enq_cmd_bnk,
   output logic                 enq_cmd_ok,
   output logic                 enq_cmd_err,
   input  logic                 enq_en,
   input  logic                 enq_wen,
   input  logic [BID_W-1:0]     enq_bnk,
   input  logic [ADDR_W-1:0]    enq_addr,
   input  logic [W-1:0]         enq_wdata,
   output logic                 enq_rvld,
   output logic [W-1:0]         enq_rdata,
   output logic                 enq_acc_err,
   input  logic [1:0]           srt_cmd,
   input  logic [BID_W-1:0]     srt_cmd_bnk,
   output logic                 srt_cmd_ok,
   output logic                 srt_cmd_err,
   input  logic                 srt_en,
   input  logic                 srt_wen,
   input  logic [BID_W-1:0]     srt_bnk,
   input  logic [ADDR_W-1:0]    srt_addr,
   input  logic [W-1:0]         srt_wdata,
   output logic                 srt_rvld,
   output logic [W-1:0]         srt_rdata,
   output logic                 srt_acc_err,
   input  logic [1:0]           deq_cmd,
   input  logic [BID_W-1:0]     deq_cmd_bnk,
   output logic                 deq_cmd_ok,
   output logic                 deq_cmd_err,
   input  logic                 deq_en,
   input  logic                 deq_wen,
   input  logic [BID_W-1:0]     deq_bnk,
   input  logic [ADDR_W-1:0]    deq_addr,
   input  logic [W-1:0]         deq_wdata,
   output logic                 deq_rvld,
   output logic [W-1:0]         deq_rdata,
   output logic                 deq_acc_err,
   output logic [2*BANKS_N-1:0] bnk_status_r,
   output logic [BANKS_N-1:0]   bnk_owned_r
);

   localparam int NC = 3;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] CMD_ACQ  = 2'd1;
   localparam logic [1:0] CMD_REL  = 2'd2;

   // client index c: 0 enq, 1 srt, 2 deq; its owner code is c+1
   logic [NC-1:0][1:0]        cmd;
   logic [NC-1:0][BID_W-1:0]  cmd_bnk;
   logic [NC-1:0]             en, wen;
   logic [NC-1:0][BID_W-1:0]  bnk;
   logic [NC-1:0][ADDR_W-1:0] addr;
   logic [NC-1:0][W-1:0]      wdata;

   assign cmd     = {deq_cmd, srt_cmd, enq_cmd};
   assign cmd_bnk = {deq_cmd_bnk, srt_cmd_bnk, enq_cmd_bnk};
   assign en      = {deq_en, srt_en, enq_en};
   assign wen     = {deq_wen, srt_wen, enq_wen};
   assign bnk     = {deq_bnk, srt_bnk, enq_bnk};
   assign addr    = {deq_addr, srt_addr, enq_addr};
   assign wdata   = {deq_wdata, srt_wdata, enq_wdata};

   logic [BANKS_N-1:0][1:0] status, status_d, owner, owner_d;
   logic [NC-1:0]           owns_any, ok_d, err_d, acc_ok;
   logic [NC-1:0]           cmd_ok, cmd_err, acc_err, rvld;
   logic [NC-1:0][BID_W-1:0] rbnk;
   logic [NC-1:0][W-1:0]     rhold, rdata;

   logic [BANKS_N-1:0]             b_en, b_wen;
   logic [BANKS_N-1:0][ADDR_W-1:0] b_addr;
   logic [BANKS_N-1:0][W-1:0]      b_wdata, bank_q;

   // Each bank admits at most one legal transition per cycle, so no ordering between clients matters.
   always_comb begin
      owns_any = '0;
      status_d = status;
      owner_d  = owner;
      ok_d     = '0;
      err_d    = '0;
      for (int b = 0; b < BANKS_N; b++)
         for (int c = 0; c < NC; c++)
            if (owner[b] == 2'(c + 1)) owns_any[c] = 1'b1;
      for (int c = 0; c < NC; c++) begin
         case (cmd[c])
            CMD_ACQ:
               if (owner[cmd_bnk[c]] == OWN_NONE && status[cmd_bnk[c]] == 2'(c) && !owns_any[c]) begin
                  owner_d[cmd_bnk[c]] = 2'(c + 1);
                  ok_d[c] = 1'b1;
               end else
                  err_d[c] = 1'b1;
            CMD_REL:
               if (owner[cmd_bnk[c]] == 2'(c + 1)) begin
                  owner_d[cmd_bnk[c]]  = OWN_NONE;
                  status_d[cmd_bnk[c]] = 2'((c + 1) % 3);
                  ok_d[c] = 1'b1;
               end else
                  err_d[c] = 1'b1;
            default: ;
         endcase
      end
   end

   // Ownership is exclusive, so each bank sees at most one accepted access.
   always_comb begin
      b_en    = '0;
      b_wen   = '0;
      b_addr  = '0;
      b_wdata = '0;
      for (int c = 0; c < NC; c++) begin
         acc_ok[c] = en[c] && (owner[bnk[c]] == 2'(c + 1));
         if (acc_ok[c]) begin
            b_en[bnk[c]]    = 1'b1;
            b_wen[bnk[c]]   = wen[c];
            b_addr[bnk[c]]  = addr[c];
            b_wdata[bnk[c]] = wdata[c];
         end
      end
   end

   for (genvar b = 0; b < BANKS_N; b++) begin : g_bank
      logic [W-1:0] mem [N];
      logic [W-1:0] q;
      always_ff @(posedge clk) begin
         if (b_en[b]) begin
            if (b_wen[b]) mem[b_addr[b]] <= b_wdata[b];
            else          q <= mem[b_addr[b]];
         end
      end
      assign bank_q[b] = q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status  <= '0;
         owner   <= '0;
         cmd_ok  <= '0;
         cmd_err <= '0;
         acc_err <= '0;
         rvld    <= '0;
         rbnk    <= '0;
         rhold   <= '0;
      end else begin
         status  <= status_d;
         owner   <= owner_d;
         cmd_ok  <= ok_d;
         cmd_err <= err_d;
         acc_err <= en & ~acc_ok;
         rvld    <= acc_ok & ~wen;
         rbnk    <= bnk;
         for (int c = 0; c < NC; c++)
            if (rvld[c]) rhold[c] <= bank_q[rbnk[c]];
      end
   end

   // Bank read register is only overwritten by that bank's owner, so it is stable during rvld.
   always_comb begin
      for (int c = 0; c < NC; c++)
         rdata[c] = rvld[c] ? bank_q[rbnk[c]] : rhold[c];
   end

   always_comb begin
      for (int b = 0; b < BANKS_N; b++) begin
         bnk_status_r[2*b +: 2] = status[b];
         bnk_owned_r[b]         = (owner[b] != OWN_NONE);
      end
   end

   assign {deq_cmd_ok, srt_cmd_ok, enq_cmd_ok}    = cmd_ok;
   assign {deq_cmd_err, srt_cmd_err, enq_cmd_err} = cmd_err;
   assign {deq_acc_err, srt_acc_err, enq_acc_err} = acc_err;
   assign {deq_rvld, srt_rvld, enq_rvld}          = rvld;
   assign enq_rdata = rdata[0];
   assign srt_rdata = rdata[1];
   assign deq_rdata = rdata[2];

   logic unused_st;
   assign unused_st = (ST_IDLE != 2'd0);

endmodule

// File: tb/tb_qs_bank_arb.sv
// Directed bench for qs_bank_arb: stimulus pushes expected command, read and
// access-error results; a negedge monitor pops and compares as the DUT reports them.
module tb_qs_bank_arb;

   localparam int W = 32;
   localparam logic [1:0] NOP = 2'd0, ACQ = 2'd1, REL = 2'd2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  cmd [3];
   logic [1:0]  cmd_bnk [3];
   logic        en [3], wen [3];
   logic [1:0]  bnk [3];
   logic [7:0]  addr [3];
   logic [31:0] wdata [3];
   logic        cmd_ok [3], cmd_err [3], rvld [3], acc_err [3];
   logic [31:0] rdata [3];
   logic [7:0]  bnk_status_r;
   logic [3:0]  bnk_owned_r;

   int vectors = 0;
   int miscompares = 0;

   logic [1:0]  cq [3][$];
   logic [31:0] rq [3][$];
   logic        aq [3][$];

   qs_bank_arb #(.BANKS_N(4), .W(W), .N(256)) dut (
      .clk(clk), .rst(rst),
      .enq_cmd(cmd[0]), .enq_cmd_bnk(cmd_bnk[0]), .enq_cmd_ok(cmd_ok[0]), .enq_cmd_err(cmd_err[0]),
      .enq_en(en[0]), .enq_wen(wen[0]), .enq_bnk(bnk[0]), .enq_addr(addr[0]), .enq_wdata(wdata[0]),
      .enq_rvld(rvld[0]), .enq_rdata(rdata[0]), .enq_acc_err(acc_err[0]),
      .srt_cmd(cmd[1]), .srt_cmd_bnk(cmd_bnk[1]), .srt_cmd_ok(cmd_ok[1]), .srt_cmd_err(cmd_err[1]),
      .srt_en(en[1]), .srt_wen(wen[1]), .srt_bnk(bnk[1]), .srt_addr(addr[1]), .srt_wdata(wdata[1]),
      .srt_rvld(rvld[1]), .srt_rdata(rdata[1]), .srt_acc_err(acc_err[1]),
      .deq_cmd(cmd[2]), .deq_cmd_bnk(cmd_bnk[2]), .deq_cmd_ok(cmd_ok[2]), .deq_cmd_err(cmd_err[2]),
      .deq_en(en[2]), .deq_wen(wen[2]), .deq_bnk(bnk[2]), .deq_addr(addr[2]), .deq_wdata(wdata[2]),
      .deq_rvld(rvld[2]), .deq_rdata(rdata[2]), .deq_acc_err(acc_err[2]),
      .bnk_status_r(bnk_status_r), .bnk_owned_r(bnk_owned_r)
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic idle_inputs();
      for (int c = 0; c < 3; c++) begin
         cmd[c] = NOP; cmd_bnk[c] = '0; en[c] = 1'b0; wen[c] = 1'b0;
         bnk[c] = '0; addr[c] = '0; wdata[c] = '0;
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic do_cmd(input int c, input logic [1:0] op, input logic [1:0] b, input logic ok);
      cmd[c] = op; cmd_bnk[c] = b;
      cq[c].push_back(ok ? 2'b10 : 2'b01);
   endtask

   task automatic do_wr(input int c, input logic [1:0] b, input logic [7:0] a, input logic [31:0] d, input logic legal);
      en[c] = 1'b1; wen[c] = 1'b1; bnk[c] = b; addr[c] = a; wdata[c] = d;
      if (!legal) aq[c].push_back(1'b1);
   endtask

   task automatic do_rd(input int c, input logic [1:0] b, input logic [7:0] a, input logic [31:0] exp, input logic legal);
      en[c] = 1'b1; wen[c] = 1'b0; bnk[c] = b; addr[c] = a;
      if (legal) rq[c].push_back(exp);
      else       aq[c].push_back(1'b1);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      for (int c = 0; c < 3; c++) begin
         if (cmd_ok[c] || cmd_err[c]) begin
            if (cq[c].size() == 0) chk($sformatf("cmd_unexpected_c%0d", c), {cmd_ok[c], cmd_err[c]}, 2'b00);
            else chk($sformatf("cmd_result_c%0d", c), {cmd_ok[c], cmd_err[c]}, cq[c].pop_front());
         end
         if (rvld[c]) begin
            if (rq[c].size() == 0) chk($sformatf("rvld_unexpected_c%0d", c), 1'b1, 1'b0);
            else chk($sformatf("rdata_c%0d", c), rdata[c], rq[c].pop_front());
         end
         if (acc_err[c]) begin
            if (aq[c].size() == 0) chk($sformatf("acc_err_unexpected_c%0d", c), 1'b1, 1'b0);
            else chk($sformatf("acc_err_c%0d", c), acc_err[c], aq[c].pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_status", bnk_status_r, 8'h00);
      chk("reset_owned", bnk_owned_r, 4'h0);
      for (int c = 0; c < 3; c++)
         chk($sformatf("reset_outs_c%0d", c), {cmd_ok[c], cmd_err[c], rvld[c], acc_err[c], rdata[c]}, '0);
      rst = 1'b0;

      // 1: enq fills b0
      do_cmd(0, ACQ, 2'd0, 1'b1); tick();
      for (int i = 0; i < 4; i++) begin
         do_wr(0, 2'd0, 8'(i), 32'hA000_0000 + 32'(i), 1'b1); tick();
      end
      do_cmd(0, REL, 2'd0, 1'b1); tick();
      chk("t1_status", bnk_status_r, 8'b0000_0001);
      chk("t1_owned", bnk_owned_r, 4'b0000);

      // 2: srt reads, releases; deq reads, releases
      do_cmd(1, ACQ, 2'd0, 1'b1); tick();
      chk("t2_owned_srt", bnk_owned_r, 4'b0001);
      do_rd(1, 2'd0, 8'd2, 32'hA000_0002, 1'b1); tick();
      do_cmd(1, REL, 2'd0, 1'b1); tick();
      chk("t2_status_sorted", bnk_status_r, 8'b0000_0010);
      do_cmd(2, ACQ, 2'd0, 1'b1); tick();
      do_rd(2, 2'd0, 8'd3, 32'hA000_0003, 1'b1); tick();
      do_cmd(2, REL, 2'd0, 1'b1); tick();
      chk("t2_status_idle", bnk_status_r, 8'b0000_0000);

      // 3: illegal commands
      do_cmd(1, ACQ, 2'd1, 1'b0);
      do_cmd(2, REL, 2'd1, 1'b0); tick();
      chk("t3_status", bnk_status_r, 8'b0000_0000);
      chk("t3_owned", bnk_owned_r, 4'b0000);

      // 4: illegal accesses
      do_cmd(0, ACQ, 2'd1, 1'b1); tick();
      do_wr(0, 2'd1, 8'd5, 32'h0000_00C5, 1'b1); tick();
      do_cmd(0, REL, 2'd1, 1'b1); tick();
      do_cmd(0, ACQ, 2'd0, 1'b1); tick();
      do_wr(0, 2'd1, 8'd5, 32'h0000_0BAD, 1'b0); tick();
      do_wr(0, 2'd0, 8'd5, 32'h0000_5555, 1'b1); tick();
      do_rd(0, 2'd0, 8'd5, 32'h0000_5555, 1'b1);
      do_cmd(0, ACQ, 2'd2, 1'b0);
      do_cmd(1, ACQ, 2'd1, 1'b1); tick();
      do_rd(1, 2'd1, 8'd5, 32'h0000_00C5, 1'b1); tick();
      do_rd(1, 2'd0, 8'd5, 32'h0, 1'b0); tick();
      do_cmd(0, REL, 2'd0, 1'b1);
      do_cmd(1, REL, 2'd1, 1'b1); tick();
      chk("t4_status", bnk_status_r, 8'b0000_1001);
      chk("t4_owned", bnk_owned_r, 4'b0000);
      chk("t4_enq_rdata_hold", rdata[0], 32'h0000_5555);

      // 5: REL and ACQ of same bank in one cycle
      do_cmd(0, ACQ, 2'd2, 1'b1); tick();
      do_cmd(0, REL, 2'd2, 1'b1);
      do_cmd(1, ACQ, 2'd2, 1'b0); tick();
      do_cmd(1, ACQ, 2'd2, 1'b1); tick();
      chk("t5_owned", bnk_owned_r, 4'b0100);
      chk("t5_status", bnk_status_r, 8'b0001_1001);
      do_wr(1, 2'd2, 8'd0, 32'h0000_00E0, 1'b1); tick();
      do_rd(1, 2'd2, 8'd0, 32'h0000_00E0, 1'b1); tick();
      do_cmd(1, REL, 2'd2, 1'b1); tick();
      chk("t5_status_sorted", bnk_status_r, 8'b0010_1001);

      // 6: async reset during a read on b3
      do_cmd(0, ACQ, 2'd3, 1'b1); tick();
      do_wr(0, 2'd3, 8'd7, 32'h0000_00D7, 1'b1); tick();
      en[0] = 1'b1; wen[0] = 1'b0; bnk[0] = 2'd3; addr[0] = 8'd7;
      #3 rst = 1'b1;
      #1;
      chk("t6_status_rst", bnk_status_r, 8'h00);
      chk("t6_owned_rst", bnk_owned_r, 4'h0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         for (int c = 0; c < 3; c++)
            chk($sformatf("t6_outs_rst_c%0d", c), {cmd_ok[c], cmd_err[c], rvld[c], acc_err[c], rdata[c]}, '0);
      end
      @(posedge clk); #1;
      idle_inputs();
      rst = 1'b0;
      tick();
      do_cmd(0, ACQ, 2'd3, 1'b1); tick();
      repeat (3) tick();

      for (int c = 0; c < 3; c++) begin
         chk($sformatf("pending_cmd_c%0d", c), cq[c].size(), 0);
         chk($sformatf("pending_rd_c%0d", c), rq[c].size(), 0);
         chk($sformatf("pending_acc_c%0d", c), aq[c].size(), 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
